// File: rtl/divider_ctrl.sv
// Sequencer for the histogram-equalisation divide stage: reads 8 CDF bins per group,
// waits out the datapath latch window, fires the dividers and commits each result group.
module divider_ctrl #(
   parameter int unsigned NUM_GROUPS = 32,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned GRP_W      = 5,
   parameter int unsigned LATCH_CYC  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              sc_mem_rd_en,
   output logic [ADDR_W-1:0] sc_mem_rd_addr1,
   output logic [ADDR_W-1:0] sc_mem_rd_addr2,
   input  logic              sc_mem_rd_data_rdy,
   output logic              div_start,
   input  logic              div_done,
   output logic              res_mem_wr_en,
   output logic [GRP_W-1:0]  res_mem_wr_addr,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      StIdle, StRdReq, StRdWait, StLatch, StDivGo, StDivWait, StWrite, StFin
   } state_e;

   localparam int unsigned    LatW    = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
   localparam logic [LatW-1:0] LatLast = LatW'(LATCH_CYC - 1);
   localparam logic [GRP_W-1:0] LastGrp = GRP_W'(NUM_GROUPS - 1);

   state_e            r_state;
   state_e            w_state_d;
   logic [GRP_W-1:0]  r_grp;
   logic [GRP_W-1:0]  w_grp_d;
   logic [LatW-1:0]   r_lat_cnt;
   logic [LatW-1:0]   w_lat_cnt_d;

   logic              w_addr_vld;
   logic              w_rd_en_d;
   logic [ADDR_W-1:0] w_rd_addr1_d;
   logic [ADDR_W-1:0] w_rd_addr2_d;
   logic              w_div_start_d;
   logic              w_wr_en_d;
   logic [GRP_W-1:0]  w_wr_addr_d;
   logic              w_busy_d;
   logic              w_done_d;

   always_comb begin
      w_state_d   = r_state;
      w_grp_d     = r_grp;
      w_lat_cnt_d = r_lat_cnt;
      // abort outranks every other transition once a frame is running
      if (r_state != StIdle && abort) begin
         w_state_d   = StIdle;
         w_grp_d     = '0;
         w_lat_cnt_d = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start && !abort) begin
                  w_state_d = StRdReq;
                  w_grp_d   = '0;
               end
            end
            StRdReq:  w_state_d = StRdWait;
            StRdWait: begin
               if (sc_mem_rd_data_rdy) begin
                  w_state_d   = StLatch;
                  w_lat_cnt_d = '0;
               end
            end
            StLatch: begin
               if (r_lat_cnt == LatLast) begin
                  w_state_d = StDivGo;
               end else begin
                  w_lat_cnt_d = r_lat_cnt + LatW'(1);
               end
            end
            StDivGo:   w_state_d = StDivWait;
            StDivWait: begin
               if (div_done) begin
                  w_state_d = StWrite;
               end
            end
            StWrite: begin
               if (r_grp == LastGrp) begin
                  w_state_d = StFin;
               end else begin
                  w_grp_d   = r_grp + GRP_W'(1);
                  w_state_d = StRdReq;
               end
            end
            StFin:   w_state_d = StIdle;
            default: w_state_d = StIdle;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so each is a clean Moore flop.
   always_comb begin
      w_addr_vld    = (w_state_d == StRdReq) || (w_state_d == StRdWait);
      w_rd_en_d     = (w_state_d == StRdReq);
      w_rd_addr1_d  = w_addr_vld ? ADDR_W'({w_grp_d, 1'b0}) : '0;
      w_rd_addr2_d  = w_addr_vld ? ADDR_W'({w_grp_d, 1'b1}) : '0;
      w_div_start_d = (w_state_d == StDivGo);
      w_wr_en_d     = (w_state_d == StWrite);
      w_wr_addr_d   = (w_state_d == StWrite) ? w_grp_d : '0;
      w_busy_d      = (w_state_d != StIdle);
      w_done_d      = (w_state_d == StFin);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= StIdle;
         r_grp           <= '0;
         r_lat_cnt       <= '0;
         sc_mem_rd_en    <= 1'b0;
         sc_mem_rd_addr1 <= '0;
         sc_mem_rd_addr2 <= '0;
         div_start       <= 1'b0;
         res_mem_wr_en   <= 1'b0;
         res_mem_wr_addr <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         r_state         <= w_state_d;
         r_grp           <= w_grp_d;
         r_lat_cnt       <= w_lat_cnt_d;
         sc_mem_rd_en    <= w_rd_en_d;
         sc_mem_rd_addr1 <= w_rd_addr1_d;
         sc_mem_rd_addr2 <= w_rd_addr2_d;
         div_start       <= w_div_start_d;
         res_mem_wr_en   <= w_wr_en_d;
         res_mem_wr_addr <= w_wr_addr_d;
         busy            <= w_busy_d;
         done            <= w_done_d;
      end
   end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: a cycle table for zero-wait timing and abort priority,
// then hand-written frame, spurious-handshake, abort and async-reset sequences.
module tb_divider_ctrl;

   localparam int unsigned NumGroups = 32;
   localparam int unsigned AddrW     = 8;
   localparam int unsigned GrpW      = 5;
   localparam int unsigned LatchCyc  = 2;
   localparam int          Bound     = 2000;

   logic             clk = 1'b0;
   logic             reset;
   logic             start, abort;
   logic             rdy_man, rdy_auto, dd_man, dd_auto;
   logic             w_rdy, w_dd;
   logic             rd_en, div_start, wr_en, busy, done;
   logic [AddrW-1:0] a1, a2;
   logic [GrpW-1:0]  wr_addr;

   assign w_rdy = rdy_man | rdy_auto;
   assign w_dd  = dd_man | dd_auto;

   always #5 clk = ~clk;

   divider_ctrl #(
      .NUM_GROUPS (NumGroups),
      .ADDR_W     (AddrW),
      .GRP_W      (GrpW),
      .LATCH_CYC  (LatchCyc)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .abort              (abort),
      .sc_mem_rd_en       (rd_en),
      .sc_mem_rd_addr1    (a1),
      .sc_mem_rd_addr2    (a2),
      .sc_mem_rd_data_rdy (w_rdy),
      .div_start          (div_start),
      .div_done           (w_dd),
      .res_mem_wr_en      (wr_en),
      .res_mem_wr_addr    (wr_addr),
      .busy               (busy),
      .done               (done)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int rd_a1_q[$], rd_a2_q[$], rd_cyc_q[$], ds_cyc_q[$], wr_q[$];
   int n_done, n_multi, last_wr_cyc, done_cyc;
   bit auto_en;
   int rdy_dly, dd_dly, rdy_cnt, dd_cnt;

   typedef struct {
      logic st, ab, rdy, dd;
      logic rd;
      int   ea1, ea2;   // negative: address not checked in this row
      logic ds, wr;
      int   ewa;
      logic bsy, dn;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(input int st, input int ab, input int rdy, input int dd,
                               input int rd, input int ea1, input int ea2, input int ds,
                               input int wr, input int ewa, input int bsy, input int dn);
      vec_t v;
      v.st = (st != 0); v.ab = (ab != 0); v.rdy = (rdy != 0); v.dd = (dd != 0);
      v.rd = (rd != 0); v.ea1 = ea1; v.ea2 = ea2; v.ds = (ds != 0); v.wr = (wr != 0);
      v.ewa = ewa; v.bsy = (bsy != 0); v.dn = (dn != 0);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_log();
      rd_a1_q.delete(); rd_a2_q.delete(); rd_cyc_q.delete(); ds_cyc_q.delete(); wr_q.delete();
      n_done = 0; last_wr_cyc = -100; done_cyc = -100;
      rdy_cnt = 0; dd_cnt = 0; rdy_auto = 1'b0; dd_auto = 1'b0;
   endtask

   // One clock: sample outputs just after the edge, log strobes, run the memory/divider model.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rd_en) begin
         rd_a1_q.push_back(int'(a1)); rd_a2_q.push_back(int'(a2)); rd_cyc_q.push_back(cyc);
      end
      if (div_start) ds_cyc_q.push_back(cyc);
      if (wr_en) begin
         wr_q.push_back(int'(wr_addr)); last_wr_cyc = cyc;
      end
      if (done) begin
         n_done++; done_cyc = cyc;
      end
      if (int'(rd_en) + int'(div_start) + int'(wr_en) > 1) n_multi++;
      if (auto_en) begin
         if (rd_en) rdy_cnt = rdy_dly + 1; else if (rdy_cnt > 0) rdy_cnt--;
         if (div_start) dd_cnt = dd_dly + 1; else if (dd_cnt > 0) dd_cnt--;
      end
      rdy_auto = auto_en && (rdy_cnt == 1);
      dd_auto  = auto_en && (dd_cnt == 1);
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // Full frame with rdy 3 cycles and div_done 10 cycles after their requests.
   // extra_grp >= 0 pulses start again while that group's read is in flight.
   task automatic run_frame(input string tag, input int extra_grp);
      bit pulsed;
      int bad;
      clear_log();
      auto_en = 1'b1; rdy_dly = 3; dd_dly = 10; pulsed = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_first_rd"}, {31'd0, rd_en}, 32'd1);
      for (int k = 0; k < 4 * Bound && n_done == 0; k++) begin
         start = (extra_grp >= 0) && !pulsed && (rd_a1_q.size() == extra_grp + 1);
         if (start) pulsed = 1'b1;
         tick();
      end
      start = 1'b0;
      check({tag, "_done_seen"}, n_done, 1);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      check({tag, "_done_after_wr"}, done_cyc - last_wr_cyc, 1);
      tick();
      check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      repeat (20) tick();
      check({tag, "_single_done"}, n_done, 1);
      check({tag, "_n_rd"}, rd_a1_q.size(), NumGroups);
      check({tag, "_n_ds"}, ds_cyc_q.size(), NumGroups);
      check({tag, "_n_wr"}, wr_q.size(), NumGroups);
      bad = 0;
      for (int g = 0; g < rd_a1_q.size(); g++)
         if (rd_a1_q[g] != 2 * g || rd_a2_q[g] != 2 * g + 1) bad++;
      check({tag, "_rd_addr_errs"}, bad, 0);
      bad = 0;
      for (int g = 0; g < wr_q.size(); g++) if (wr_q[g] != g) bad++;
      check({tag, "_wr_addr_errs"}, bad, 0);
      bad = 0;
      for (int g = 0; g < rd_cyc_q.size() && g < ds_cyc_q.size(); g++)
         if (ds_cyc_q[g] - rd_cyc_q[g] != rdy_dly + LatchCyc + 1) bad++;
      check({tag, "_rd_to_ds_errs"}, bad, 0);
      auto_en = 1'b0;
   endtask

   initial begin
      logic [25:0] act_v, exp_v;
      int a1m, a2m, wam;

      // rd_en, addr1, addr2, div_start, wr_en, wr_addr, busy, done; rdy and div_done tied high
      tbl[0]  = mk(1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
      tbl[1]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0);
      tbl[2]  = mk(0, 0, 1, 1, 0, -1, -1, 0, 0, 0, 1, 0);
      tbl[3]  = mk(0, 0, 1, 1, 0, -1, -1, 0, 0, 0, 1, 0);
      tbl[4]  = mk(0, 0, 1, 1, 0, -1, -1, 1, 0, 0, 1, 0);
      tbl[5]  = mk(0, 0, 1, 1, 0, -1, -1, 0, 0, 0, 1, 0);
      tbl[6]  = mk(0, 0, 1, 1, 0, -1, -1, 0, 1, 0, 1, 0);
      tbl[7]  = mk(0, 0, 1, 1, 1, 2, 3, 0, 0, 0, 1, 0);
      tbl[8]  = mk(0, 0, 1, 1, 0, 2, 3, 0, 0, 0, 1, 0);
      tbl[9]  = mk(0, 1, 1, 1, 0, -1, -1, 0, 0, 0, 0, 0);
      tbl[10] = mk(1, 1, 1, 1, 0, -1, -1, 0, 0, 0, 0, 0);
      tbl[11] = mk(1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
      tbl[12] = mk(0, 1, 1, 1, 0, -1, -1, 0, 0, 0, 0, 0);

      start = 1'b0; abort = 1'b0; rdy_man = 1'b0; dd_man = 1'b0;
      auto_en = 1'b0; n_multi = 0;
      clear_log();
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      check("reset_outputs", {6'd0, rd_en, a1, a2, div_start, wr_en, wr_addr, busy, done}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Zero-wait cycle table
      for (int i = 0; i < 13; i++) begin
         start = tbl[i].st; abort = tbl[i].ab; rdy_man = tbl[i].rdy; dd_man = tbl[i].dd;
         tick();
         a1m = (tbl[i].ea1 < 0) ? 0 : int'(a1);
         a2m = (tbl[i].ea2 < 0) ? 0 : int'(a2);
         wam = tbl[i].wr ? int'(wr_addr) : 0;
         act_v = {rd_en, a1m[7:0], a2m[7:0], div_start, wr_en, wam[4:0], busy, done};
         a1m = (tbl[i].ea1 < 0) ? 0 : tbl[i].ea1;
         a2m = (tbl[i].ea2 < 0) ? 0 : tbl[i].ea2;
         wam = tbl[i].wr ? tbl[i].ewa : 0;
         exp_v = {tbl[i].rd, a1m[7:0], a2m[7:0], tbl[i].ds, tbl[i].wr, wam[4:0],
                  tbl[i].bsy, tbl[i].dn};
         check($sformatf("tbl_row%0d", i), {6'd0, act_v}, {6'd0, exp_v});
      end
      start = 1'b0; abort = 1'b0; rdy_man = 1'b0; dd_man = 1'b0;
      tick();

      run_frame("frame", -1);

      // Spurious handshakes outside their sampling states
      clear_log();
      start = 1'b1; tick(); start = 1'b0;
      tick();
      dd_man = 1'b1; tick(); dd_man = 1'b0;
      check("spur_dd_in_rdwait", {7'd0, rd_en, div_start, wr_en, busy, a1, a2},
            {7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1});
      rdy_man = 1'b1; tick(); rdy_man = 1'b0;
      tick(); tick();
      check("spur_ds_timing", {31'd0, div_start}, 32'd1);
      tick();
      rdy_man = 1'b1; tick(); rdy_man = 1'b0;
      tick();
      check("spur_rdy_in_divwait", {29'd0, rd_en, div_start, wr_en}, 0);
      check("spur_rd_count", rd_a1_q.size(), 1);
      dd_man = 1'b1; tick(); dd_man = 1'b0;
      check("spur_wr", {26'd0, wr_en, wr_addr}, {26'd0, 1'b1, 5'd0});
      tick();
      check("spur_next_rd", {15'd0, rd_en, a1, a2}, {15'd0, 1'b1, 8'd2, 8'd3});
      do_abort();

      // Abort during DIV_WAIT of group 5
      clear_log();
      auto_en = 1'b1; rdy_dly = 3; dd_dly = 10;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < Bound && ds_cyc_q.size() < 6; k++) tick();
      check("abort_reach_grp5", ds_cyc_q.size(), 6);
      tick();
      do_abort();
      check("abort_outputs", {27'd0, rd_en, div_start, wr_en, busy, done}, 0);
      repeat (30) tick();
      check("abort_no_wr5", wr_q.size(), 5);
      check("abort_no_done", n_done, 0);
      clear_log();
      start = 1'b1; tick(); start = 1'b0;
      check("abort_restart", {15'd0, rd_en, a1, a2}, {15'd0, 1'b1, 8'd0, 8'd1});
      do_abort();

      // Async reset in RD_WAIT of group 12
      clear_log();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < Bound && rd_a1_q.size() < 13; k++) tick();
      check("rst_reach_grp12", rd_a1_q.size(), 13);
      tick();
      check("rst_rdwait_addr", {16'd0, a1, a2}, {16'd0, 8'd24, 8'd25});
      #3 reset = 1'b0;
      #1;
      check("rst_async_outputs", {6'd0, rd_en, a1, a2, div_start, wr_en, wr_addr, busy, done}, 0);
      auto_en = 1'b0;
      clear_log();
      tick(); tick();
      reset = 1'b1;
      repeat (3) tick();
      check("rst_idle_after", {30'd0, busy, done}, 0);
      start = 1'b1; tick(); start = 1'b0;
      check("rst_restart", {15'd0, rd_en, a1, a2}, {15'd0, 1'b1, 8'd0, 8'd1});
      do_abort();
      tick();

      run_frame("busy_start", 3);

      check("strobe_exclusive", n_multi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
